// File: rtl/serial_bus_pkg.sv
// Shared types and default widths for the serial master/slave bus slave endpoint.
package serial_bus_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BUSY_CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_RDATA  = 3'd5,
    ST_BUSY   = 3'd6
  } slave_state_e;

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM with a registered read port; swappable for a block-RAM macro.
module slave_bram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Read-before-write: dout returns the old word on a same-cycle write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/serial_slave_port.sv
// Slave endpoint of the serial bus: shifts in address/write data, accesses local RAM,
// shifts read data back out under bus_ready flow control, with an optional busy tail.
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned BUSY_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic address,
  input  logic data,
  input  logic valid,
  input  logic write_en,
  input  logic bus_ready,
  output logic ready,
  output logic data_out,
  output logic valid_out
);

  localparam int unsigned CNT_MAX  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned BRAM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam slave_state_e POST_ACC = (BUSY_CYCLES != 0) ? ST_BUSY : ST_IDLE;

  slave_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    wr_q, wr_d;
  logic [BUSY_CNT_W-1:0]   busy_q, busy_d;
  logic                    ready_q;

  logic                    in_range;
  logic                    bram_we;
  logic [DATA_WIDTH-1:0]   bram_dout;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
  assign bram_we  = (state_q == ST_MEM_WR) && in_range;

  // RAM is addressed with the next address so the read word is ready during MEM_RD.
  slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (BRAM_AW)
  ) u_bram (
    .clk  (clk),
    .we   (bram_we),
    .addr (addr_d[BRAM_AW-1:0]),
    .din  (wdata_q),
    .dout (bram_dout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          addr_d = ADDR_WIDTH'({addr_q, address});
          wr_d   = write_en;
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = write_en ? ST_WDATA : ST_MEM_RD;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (valid) begin
          addr_d = ADDR_WIDTH'({addr_q, address});
          if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = wr_q ? ST_WDATA : ST_MEM_RD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (valid) begin
          wdata_d = DATA_WIDTH'({wdata_q, data});
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_MEM_WR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_MEM_WR: begin
        busy_d  = BUSY_CNT_W'(BUSY_CYCLES);
        state_d = POST_ACC;
      end
      ST_MEM_RD: begin
        rdata_d = in_range ? bram_dout : '0;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (bus_ready) begin
          rdata_d = DATA_WIDTH'({rdata_q, 1'b0});
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            busy_d  = BUSY_CNT_W'(BUSY_CYCLES);
            state_d = POST_ACC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (busy_q <= BUSY_CNT_W'(1)) begin
          busy_d  = '0;
          state_d = ST_IDLE;
        end else begin
          busy_d = busy_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      busy_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Return data follows bus_ready in the same cycle so a paused bit is never lost.
  assign ready     = ready_q;
  assign valid_out = (state_q == ST_RDATA) && bus_ready;
  assign data_out  = valid_out & rdata_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench: default slave (u_dut0) and a slow, 1K-word slave (u_dut1).
module tb_serial_slave_port;

  logic clk;
  logic rst_n;
  logic address   [2];
  logic data      [2];
  logic valid     [2];
  logic write_en  [2];
  logic bus_ready [2];
  logic ready     [2];
  logic data_out  [2];
  logic valid_out [2];

  int n_checks;
  int n_pass;

  serial_slave_port u_dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .address   (address[0]),
    .data      (data[0]),
    .valid     (valid[0]),
    .write_en  (write_en[0]),
    .bus_ready (bus_ready[0]),
    .ready     (ready[0]),
    .data_out  (data_out[0]),
    .valid_out (valid_out[0])
  );

  serial_slave_port #(
    .MEM_DEPTH   (1024),
    .BUSY_CYCLES (12)
  ) u_dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .address   (address[1]),
    .data      (data[1]),
    .valid     (valid[1]),
    .write_en  (write_en[1]),
    .bus_ready (bus_ready[1]),
    .ready     (ready[1]),
    .data_out  (data_out[1]),
    .valid_out (valid_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    for (int k = 0; k < 200 && !ready[d]; k++) begin
      @(negedge clk);
    end
    chk("idle_ready", 32'(ready[d]), 32'd1);
  endtask

  // Latency is the cycle index (first address bit = cycle 0) at which ready is seen high.
  task automatic do_write(input string tag, input int d, input logic [11:0] a,
                          input logic [7:0] w, input int stall_after, input int stall_len,
                          input int exp_lat);
    int cyc;
    int lat;
    wait_idle(d);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      valid[d] = 1'b1; write_en[d] = 1'b1; address[d] = a[11-i]; data[d] = 1'b0;
      @(negedge clk); cyc++;
      if (i == 0) chk({tag, "_ready_drop"}, 32'(ready[d]), 32'd0);
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          valid[d] = 1'b0; address[d] = ~address[d];
          @(negedge clk); cyc++;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      valid[d] = 1'b1; write_en[d] = 1'b0; data[d] = w[7-i]; address[d] = ~address[d];
      @(negedge clk); cyc++;
    end
    valid[d] = 1'b0; data[d] = 1'b0; address[d] = 1'b0;
    lat = -1;
    for (int k = 0; k < 64 && lat < 0; k++) begin
      if (ready[d]) lat = cyc;
      else begin
        @(negedge clk); cyc++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_read(input int d, input logic [11:0] a, input int pause_after,
                         input int pause_len, output logic [7:0] word, output int nbits,
                         output int first_lat, output int span, output int paused);
    int cyc;
    int first;
    int last;
    int pcnt;
    wait_idle(d);
    bus_ready[d] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      valid[d] = 1'b1; write_en[d] = 1'b0; address[d] = a[11-i];
      @(negedge clk);
    end
    valid[d] = 1'b0; address[d] = 1'b0;
    cyc = 12; nbits = 0; first = -1; last = -1; pcnt = 0; paused = 0; word = '0;
    for (int k = 0; k < 64 && nbits < 8; k++) begin
      if (nbits == pause_after && pcnt < pause_len) begin
        bus_ready[d] = 1'b0; pcnt++;
      end else begin
        bus_ready[d] = 1'b1;
      end
      #1;
      if (!bus_ready[d] && !valid_out[d] && !data_out[d]) paused++;
      if (valid_out[d]) begin
        if (first < 0) first = cyc;
        last = cyc;
        word = {word[6:0], data_out[d]};
        nbits++;
      end
      @(negedge clk); cyc++;
    end
    bus_ready[d] = 1'b1;
    #1;
    chk("rd_no_extra_bit", 32'(valid_out[d]), 32'd0);
    first_lat = first - 11;
    span = last - first;
  endtask

  logic [7:0] word;
  int nbits;
  int lat;
  int span;
  int paused;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      address[d] = 1'b0; data[d] = 1'b0; valid[d] = 1'b0;
      write_en[d] = 1'b0; bus_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(ready[d]), 32'd1);
      chk("rst_valid_out", 32'(valid_out[d]), 32'd0);
      chk("rst_data_out", 32'(data_out[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Default slave: basic write/read and 21-cycle write turnaround.
    do_write("wr010", 0, 12'h010, 8'h00, -1, 0, 21);
    do_write("wr0a5", 0, 12'h0A5, 8'h3C, -1, 0, 21);
    do_read(0, 12'h0A5, 99, 0, word, nbits, lat, span, paused);
    chk("rd0a5_word", 32'(word), 32'h3C);
    chk("rd0a5_bits", 32'(nbits), 32'd8);
    chk("rd0a5_first_lat", 32'(lat), 32'd2);
    chk("rd0a5_span", 32'(span), 32'd7);

    // Stall for 3 cycles after address bit 5.
    do_write("wr7ff_stall", 0, 12'h7FF, 8'hFF, 5, 3, 24);
    do_read(0, 12'h7FF, 99, 0, word, nbits, lat, span, paused);
    chk("rd7ff_word", 32'(word), 32'hFF);
    chk("rd7ff_bits", 32'(nbits), 32'd8);

    // bus_ready low for 4 cycles after the third bit.
    do_read(0, 12'h0A5, 3, 4, word, nbits, lat, span, paused);
    chk("pause_word", 32'(word), 32'h3C);
    chk("pause_bits", 32'(nbits), 32'd8);
    chk("pause_low_cycles", 32'(paused), 32'd4);
    chk("pause_span", 32'(span), 32'd11);

    // Slow slave: 12 busy cycles after every access.
    do_write("busy_wr0a5", 1, 12'h0A5, 8'h3C, -1, 0, 33);
    do_read(1, 12'h0A5, 99, 0, word, nbits, lat, span, paused);
    chk("busy_rd_word", 32'(word), 32'h3C);
    chk("busy_rd_first_lat", 32'(lat), 32'd2);

    // Out-of-range: 0xC00 aliases 0x000 in a 1K RAM, so a leaked write would show up there.
    do_write("wr000", 1, 12'h000, 8'h77, -1, 0, 33);
    do_write("wrc00_oor", 1, 12'hC00, 8'h5A, -1, 0, 33);
    do_read(1, 12'h000, 99, 0, word, nbits, lat, span, paused);
    chk("rd000_word", 32'(word), 32'h77);
    do_read(1, 12'hC00, 99, 0, word, nbits, lat, span, paused);
    chk("rdc00_word", 32'(word), 32'h00);
    chk("rdc00_bits", 32'(nbits), 32'd8);
    chk("rdc00_span", 32'(span), 32'd7);

    // Reset during the 4th data bit of write 0x010/0xAA.
    wait_idle(0);
    for (int i = 0; i < 12; i++) begin
      valid[0] = 1'b1; write_en[0] = 1'b1; address[0] = (i == 7);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      valid[0] = 1'b1; data[0] = (i % 2 == 0);
      @(negedge clk);
    end
    valid[0] = 1'b1; data[0] = 1'b0;
    chk("midrst_busy", 32'(ready[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready[0]), 32'd1);
    chk("midrst_valid_out", 32'(valid_out[0]), 32'd0);
    valid[0] = 1'b0; data[0] = 1'b0; address[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(0, 12'h010, 99, 0, word, nbits, lat, span, paused);
    chk("midrst_rd010_word", 32'(word), 32'h00);
    chk("midrst_rd010_bits", 32'(nbits), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
